// File: rtl/rf_pkg.sv
// Shared definitions for the integer and FP register files:
// default sizes, address-width helper and common word/address types.
package rf_pkg;

    localparam int unsigned RF_XLEN  = 32;
    localparam int unsigned RF_NREGS = 32;
    localparam int unsigned RF_AW    = $clog2(RF_NREGS);

    function automatic int unsigned rf_aw(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    typedef logic [RF_XLEN-1:0] xword_t;
    typedef logic [RF_AW-1:0]   raddr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback,
// looked up per read port to flag RAW hazards.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS    = RF_NREGS,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = rf_aw(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_iss_valid,
    input  logic [AW-1:0]     i_iss_addr,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [NRD*AW-1:0] i_raddr,
    output logic [NRD-1:0]    o_busy
);

    localparam logic ZR  = (ZERO_REG != 0);
    localparam logic BYP = (BYPASS != 0);

    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_d;

    // Set is applied after clear so a same-edge reissue keeps the register pending.
    always_comb begin
        w_pend_d = r_pend;
        if (i_we) begin
            w_pend_d[i_waddr] = 1'b0;
        end
        if (i_iss_valid && !(ZR && (i_iss_addr == '0))) begin
            w_pend_d[i_iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_busy
        logic [AW-1:0] w_ra;
        assign w_ra      = i_raddr[k*AW +: AW];
        assign o_busy[k] = r_pend[w_ra] & ~(BYP & i_we & (i_waddr == w_ra));
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional write bypass, hard-wired
// zero register, registered read copy and a pending-write scoreboard.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = RF_XLEN,
    parameter int unsigned NREGS    = RF_NREGS,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = rf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ari,
    output logic [NRD*XLEN-1:0] rdo,
    output logic [NRD*XLEN-1:0] rddo,
    output logic [NRD-1:0]      busyo,
    input  logic [AW-1:0]       ar3i,
    input  logic [XLEN-1:0]     r3i,
    input  logic                we3,
    input  logic                issvi,
    input  logic [AW-1:0]       issai
);

    localparam logic ZR  = (ZERO_REG != 0);
    localparam logic BYP = (BYPASS != 0);

    logic [XLEN-1:0]     r_regs [NREGS];
    logic [NRD*XLEN-1:0] r_rddo;
    logic                w_wr_en;

    assign w_wr_en = we3 & ~(ZR & (ar3i == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[ar3i] <= r3i;
        end
    end

    // Bypass is gated by reset so the read ports show the cleared file while rst is low.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_hit;
        assign w_ra  = ari[k*AW +: AW];
        assign w_hit = BYP & rst & we3 & (ar3i == w_ra);
        assign rdo[k*XLEN +: XLEN] = (ZR & (w_ra == '0)) ? '0 :
                                     w_hit               ? r3i : r_regs[w_ra];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rddo <= '0;
        end else begin
            r_rddo <= rdo;
        end
    end

    assign rddo = r_rddo;

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst),
        .i_iss_valid (issvi),
        .i_iss_addr  (issai),
        .i_we        (we3),
        .i_waddr     (ar3i),
        .i_raddr     (ari),
        .o_busy      (busyo)
    );

endmodule
